// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : RV32I 5-stage stall/flush/forwarding control with MEM-wait FSM
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic        rd_wrenE,
    input  logic [1:0]  wb_selE,
    input  logic [4:0]  rdM,
    input  logic        rd_wrenM,
    input  logic [4:0]  rdW,
    input  logic        rd_wrenW,
    input  logic        pc_selE,
    input  logic        mem_reqM,
    input  logic        mem_ackM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushW,
    output logic [1:0]  fwd_aE,
    output logic [1:0]  fwd_bE,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wcnt;
    logic [7:0] wcnt_nxt;
    logic       tmo;
    logic       mem_stall;
    logic       load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wen_m,
                                           input logic [4:0] rd_m,
                                           input logic       wen_w,
                                           input logic [4:0] rd_w);
        if (wen_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wen_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_aE = fwd_sel(rs1E, rd_wrenM, rdM, rd_wrenW, rdW);
    assign fwd_bE = fwd_sel(rs2E, rd_wrenM, rdM, rd_wrenW, rdW);

    // Timeout release overrides the outstanding request so the pipeline moves on.
    assign tmo       = (state == WAIT) && (wcnt == TMO_LAST);
    assign mem_stall = mem_reqM & ~mem_ackM & ~tmo;
    assign load_use  = rd_wrenE & (wb_selE == 2'b01) & (rdE != 5'd0) &
                       ((rdE == rs1D) | (rdE == rs2D));
    assign mem_err   = tmo;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (pc_selE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = 8'd1;
                end
            end
            WAIT: begin
                if (mem_ackM || tmo) begin
                    state_nxt = RUN;
                    wcnt_nxt  = 8'd0;
                end else begin
                    wcnt_nxt  = wcnt + 8'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                wcnt_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RUN;
            wcnt      <= 8'd0;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (stallF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flushE)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire
